// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NUM_REQ requesters, with a back-pressured result register.
// Optional per-requester saturating accept counters are enabled by defining ALU_ARB_STATS_EN.

package alu_pkg;
  typedef enum logic [3:0] {
    Add, Sub, And, Or, Xor, Sll, Srl, Sra, Slt, Sltu, Eq, Neq
  } alu_ops;
endpackage

module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ops      op,
  output logic [31:0] out
);
  always_comb begin
    out = '0;
    unique case (op)
      Add:  out = a + b;
      Sub:  out = a - b;
      And:  out = a & b;
      Or:   out = a | b;
      Xor:  out = a ^ b;
      Sll:  out = a << b[4:0];
      Srl:  out = a >> b[4:0];
      Sra:  out = 32'($signed(a) >>> b[4:0]);
      Slt:  out = {31'd0, $signed(a) < $signed(b)};
      Sltu: out = {31'd0, a < b};
      Eq:   out = {31'd0, a == b};
      Neq:  out = {31'd0, a != b};
      default: out = '0;
    endcase
  end
endmodule

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  alu_ops                req_op [NUM_REQ],
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output alu_ops                resp_op
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                can_accept;
  logic                accept;
  logic [31:0]         sel_a, sel_b, alu_out;
  alu_ops              sel_op;

  // Rotating priority: scan starts just after the last granted requester.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = Add;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[i];
      end
    end
  end

  alu u_alu (
    .a   (sel_a),
    .b   (sel_b),
    .op  (sel_op),
    .out (alu_out)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (resp_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    resp_valid = (state == FULL);
    can_accept = rst_n && ((state == EMPTY) || resp_ready);
    req_ready  = can_accept ? grant : '0;
    accept     = |req_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_data  <= '0;
      resp_id    <= '0;
      resp_op    <= Add;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      resp_data  <= alu_out;
      resp_id    <= grant_idx;
      resp_op    <= sel_op;
      last_grant <= grant_idx;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!rst_n)
        cnt[i] <= '0;
      else if (req_ready[i] && (cnt[i] != '1))
        cnt[i] <= cnt[i] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      grant_cnt[16*i +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by randomized traffic against a reference model.
// Define ALU_ARB_STATS_EN to also check the accept counters.

module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned IDW = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  alu_ops            req_op [N];
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [IDW-1:0]    resp_id;
  alu_ops            resp_op;
`ifdef ALU_ARB_STATS_EN
  logic [N*16-1:0]   grant_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit          m_valid;
  logic [31:0] m_data;
  int          m_id;
  alu_ops      m_op;
  int          m_last;
  int          m_cnt [N];
  logic [N-1:0] acc_mask;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_op    (resp_op)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input alu_ops op);
    int unsigned sh;
    logic [31:0] fill;
    sh = int'(b % 32);
    fill = (sh == 0) ? 32'd0 : ~(32'hFFFF_FFFF >> sh);
    case (op)
      Add:  return a + b;
      Sub:  return a + (~b + 32'd1);
      And:  return a & b;
      Or:   return a | b;
      Xor:  return a ^ b;
      Sll:  return a * (32'd1 << sh);
      Srl:  return a / (32'd1 << sh);
      Sra:  return (a / (32'd1 << sh)) | (a[31] ? fill : 32'd0);
      Slt:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      Sltu: return (a < b) ? 32'd1 : 32'd0;
      Eq:   return (a == b) ? 32'd1 : 32'd0;
      Neq:  return (a == b) ? 32'd0 : 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_op    = Add;
    m_last  = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  function automatic int pick();
    int i;
    if (!rst_n || (m_valid && !resp_ready)) return -1;
    for (int k = 1; k <= N; k++) begin
      i = (m_last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check handshake before the edge, advance the model at the edge, check outputs after it.
  task automatic tick();
    int g;
    logic [N-1:0] er;
    #1;
    g  = pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    acc_mask = '0;
    if (!rst_n) model_reset();
    else if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = ref_alu(req_a[32*g +: 32], req_b[32*g +: 32], req_op[g]);
      m_id    = g;
      m_op    = req_op[g];
      m_last  = g;
      if (m_cnt[g] < 65535) m_cnt[g]++;
      acc_mask[g] = 1'b1;
    end else if (m_valid && resp_ready) m_valid = 1'b0;
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    check("resp_data", resp_data, m_data);
    check("resp_id", 32'(resp_id), 32'(m_id));
    check("resp_op", 32'(resp_op), 32'(m_op));
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check("grant_cnt", 32'(grant_cnt[16*i +: 16]), 32'(m_cnt[i]));
`endif
  endtask

  task automatic set_req(input int i, input alu_ops op, input logic [31:0] a, input logic [31:0] b);
    req_op[i]         = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    for (int i = 0; i < N; i++) req_op[i] = Add;
    resp_ready = 1'b0;
    acc_mask   = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_data", resp_data, 32'd0);

    // single op
    rst_n = 1'b1;
    set_req(0, Add, 32'd5, 32'd3);
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    #1 check("single_ready", 32'(req_ready), 32'd1);
    tick();
    check("single_valid", 32'(resp_valid), 32'd1);
    check("single_data", resp_data, 32'd8);
    check("single_id", 32'(resp_id), 32'd0);
    check("single_op", 32'(resp_op), 32'(Add));
    req_valid = '0;
    tick();

    // round robin from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, Sub, 32'd10, 32'd4);
    set_req(1, Sll, 32'd1, 32'h24);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_id", 32'(resp_id), 32'(k % 2));
      check("rr_data", resp_data, (k % 2) ? 32'd16 : 32'd6);
      check("rr_valid", 32'(resp_valid), 32'd1);
    end
    req_valid = '0;
    tick();

    // back-pressure
    set_req(0, Add, 32'd5, 32'd3);
    req_valid = 2'b01;
    tick();
    req_valid  = 2'b10;
    set_req(1, Sub, 32'd20, 32'd5);
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_hold", resp_data, 32'd8);
    end
    resp_ready = 1'b1;
    #1 check("bp_release", 32'(req_ready), 32'b10);
    tick();
    check("bp_new_data", resp_data, 32'd15);
    check("bp_new_id", 32'(resp_id), 32'd1);

    // signed ops on requester 1
    set_req(1, Sra, 32'h8000_0000, 32'd4);
    tick();
    check("sra", resp_data, 32'hF800_0000);
    set_req(1, Slt, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt", resp_data, 32'd1);
    set_req(1, Sltu, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("sltu", resp_data, 32'd0);

    // reset while a result is pending
    req_valid = 2'b11;
    rst_n     = 1'b0;
    tick();
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_data", resp_data, 32'd0);
    check("midrst_id", 32'(resp_id), 32'd0);
    rst_n = 1'b1;
    set_req(0, Add, 32'd1, 32'd2);
    set_req(1, Sub, 32'd9, 32'd1);
    #1 check("midrst_first", 32'(req_ready), 32'b01);
    tick();
    check("midrst_first_id", 32'(resp_id), 32'd0);
    check("midrst_first_data", resp_data, 32'd3);
    req_valid = '0;
    tick();

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !acc_mask[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, alu_ops'($urandom_range(0, 11)), $urandom,
                  $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40)));
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      rst_n      = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n     = 1'b1;
    req_valid = '0;
    tick();

`ifdef ALU_ARB_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    set_req(0, Add, 32'd1, 32'd1);
    set_req(1, Xor, 32'd3, 32'd1);
    req_valid = 2'b11;
    repeat (6) tick();
    req_valid = 2'b01;
    repeat (2) tick();
    req_valid = '0;
    tick();
    check("stats_5_3", grant_cnt, {16'd3, 16'd5});
    req_valid = 2'b01;
    repeat (65536) tick();
    req_valid = '0;
    tick();
    check("stats_sat", 32'(grant_cnt[15:0]), 32'h0000_FFFF);
    check("stats_other", 32'(grant_cnt[31:16]), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
